// File: rtl/pipo_write_arbiter.sv
// Round-robin write arbiter and load sequencer for a shared WIDTH-bit PIPO register.
// One transfer takes three cycles: IDLE (arbitrate) -> GRANT (load) -> ACK (complete).
module pipo_write_arbiter #(
    parameter  int WIDTH = 4,
    parameter  int NREQ  = 4,
    localparam int IW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic [IW-1:0]         owner,
    output logic                  busy,
    output logic [7:0]            load_cnt
);

    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, win, sel;
    logic          any;
    int            idx;

    // First requesting index at or after ptr, wrapping; ptr holds last winner + 1.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any && req[idx]) begin
                any = 1'b1;
                sel = IW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any) state_nxt = GRANT;
            GRANT:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt      <= '0;
            ack      <= '0;
            q        <= '0;
            owner    <= '0;
            load_cnt <= '0;
            ptr      <= '0;
            win      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        gnt <= NREQ'(1) << sel;
                        win <= sel;
                    end
                end
                // Load is committed here regardless of req[win] dropping.
                GRANT: begin
                    q        <= din[win*WIDTH +: WIDTH];
                    owner    <= win;
                    load_cnt <= load_cnt + 8'd1;
                    ack      <= NREQ'(1) << win;
                end
                ACK: begin
                    gnt <= '0;
                    ack <= '0;
                    ptr <= (win == IW'(NREQ-1)) ? '0 : win + IW'(1);
                end
                default: begin
                    gnt <= '0;
                    ack <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pipo_write_arbiter.sv
// Directed bench for pipo_write_arbiter: reset, single/continuous requests,
// fairness, early withdrawal, abort during GRANT and load counter wrap.
module tb_pipo_write_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic [1:0]            owner;
    logic                  busy;
    logic [7:0]            load_cnt;

    int checks = 0;
    int errors = 0;

    pipo_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .ack(ack),
        .q(q), .owner(owner), .busy(busy), .load_cnt(load_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " gnt"},      gnt,      0);
        chk({tag, " ack"},      ack,      0);
        chk({tag, " q"},        q,        0);
        chk({tag, " owner"},    owner,    0);
        chk({tag, " busy"},     busy,     0);
        chk({tag, " load_cnt"}, load_cnt, 0);
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b0;
        #1;
        chk_reset_state("rst pulse");
        tick();
        rst = 1'b1;
    endtask

    // One full transfer from IDLE; drop clears req while GRANT is active.
    task automatic xfer(input int w, input logic [3:0] dexp, input logic [7:0] cexp,
                        input bit drop);
        logic [3:0] oh;
        oh = 4'b0001 << w;
        tick();
        chk("E0 gnt",  gnt,  oh);
        chk("E0 busy", busy, 1);
        chk("E0 ack",  ack,  0);
        if (drop) req = '0;
        tick();
        chk("E1 gnt",      gnt,      oh);
        chk("E1 ack",      ack,      oh);
        chk("E1 q",        q,        dexp);
        chk("E1 owner",    owner,    w);
        chk("E1 load_cnt", load_cnt, cexp);
        tick();
        chk("E2 gnt",      gnt,      0);
        chk("E2 ack",      ack,      0);
        chk("E2 busy",     busy,     0);
        chk("E2 q",        q,        dexp);
        chk("E2 load_cnt", load_cnt, cexp);
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        din = '0;
        #1;
        chk_reset_state("power-on");
        tick();
        rst = 1'b1;

        // Random traffic, then asynchronous reset between edges.
        for (int i = 0; i < 7; i++) begin
            req = 4'($urandom);
            din = 16'($urandom);
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        chk_reset_state("async rst");
        tick();
        chk_reset_state("rst held");
        tick();
        chk_reset_state("rst held2");
        req = '0;
        rst = 1'b1;

        // Single request from requester 1.
        din = 16'h00A0;
        req = 4'b0010;
        xfer(1, 4'hA, 8'd1, 1'b0);
        req = '0;
        tick();
        chk("single idle gnt", gnt, 0);
        chk("single idle q",   q,   4'hA);

        // Continuous requests from all: 0,1,2,3,0 then 1,2.
        do_reset();
        din = 16'h4321;
        req = 4'b1111;
        xfer(0, 4'h1, 8'd1, 1'b0);
        xfer(1, 4'h2, 8'd2, 1'b0);
        xfer(2, 4'h3, 8'd3, 1'b0);
        xfer(3, 4'h4, 8'd4, 1'b0);
        xfer(0, 4'h1, 8'd5, 1'b0);
        xfer(1, 4'h2, 8'd6, 1'b0);
        xfer(2, 4'h3, 8'd7, 1'b0);

        // Fairness after winner 2: 3 before 0, then 0 alone.
        req = 4'b1001;
        xfer(3, 4'h4, 8'd8, 1'b0);
        req = 4'b0001;
        xfer(0, 4'h1, 8'd9, 1'b0);

        // Early withdrawal of requester 2 during GRANT.
        din = 16'h0700;
        req = 4'b0100;
        xfer(2, 4'h7, 8'd10, 1'b1);
        tick();
        chk("withdraw idle gnt", gnt, 0);
        chk("withdraw idle busy", busy, 0);

        // Abort: reset asserted while in GRANT.
        din = 16'h0050;
        req = 4'b0010;
        tick();
        chk("abort E0 gnt", gnt, 4'b0010);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_state("abort");
        req = '0;
        tick();
        chk_reset_state("abort held");
        rst = 1'b1;
        tick();
        tick();
        chk("abort after q",        q,        0);
        chk("abort after load_cnt", load_cnt, 0);
        chk("abort after ack",      ack,      0);

        // 256 loads from requester 0 wrap the counter back to zero.
        din = 16'h000C;
        req = 4'b0001;
        for (int n = 1; n <= 256; n++) xfer(0, 4'hC, 8'(n), 1'b0);
        req = '0;
        tick();
        chk("wrap load_cnt", load_cnt, 0);
        chk("wrap q",        q,        4'hC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
